// File: rtl/nfc_mem_cor.sv
// ECC result consumer: drains parity into the page-buffer spare area, or flips error bits in place.
// Latency: encode 2*PAR_WORDS+1 cycles to cor_done; decode 1 + 4/in-range error + 2/parity error + 1.
// No backpressure: the FIFO and page buffer are assumed always ready; start pulses while busy are dropped.
module nfc_mem_cor #(
   parameter int DAT_WID   = 16,
   parameter int ECC_AWID  = 13,
   parameter int BUF_AWID  = 9,
   parameter int DATA_BITS = 4096,
   parameter int PAR_WORDS = 7,
   parameter int PAR_OFS   = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                nfc_dat_dir,
   input  logic                nfc_ecc_opt,
   input  logic                ecc_enc_rdy,
   input  logic                ecc_dec_rdy,
   input  logic [3:0]          ecc_err_num,
   input  logic                ecc_fail,
   input  logic [BUF_AWID-1:0] sec_base,
   output logic                mem_if_rd,
   input  logic [DAT_WID-1:0]  mem_enc_dat,
   input  logic [ECC_AWID-1:0] mem_dec_addr,
   output logic [BUF_AWID-1:0] buf_addr,
   output logic                buf_rd,
   output logic                buf_wr,
   output logic [DAT_WID-1:0]  buf_wdat,
   input  logic [DAT_WID-1:0]  buf_rdat,
   output logic                cor_busy,
   output logic                cor_done,
   output logic                cor_fail,
   output logic [3:0]          cor_cnt
);

   localparam int IW = (PAR_WORDS > 16) ? $clog2(PAR_WORDS) : 4;

   typedef enum logic [2:0] {IDLE, E_RD, E_WR, D_RD, D_CAP, D_BRD, D_MOD, DONE} state_t;

   state_t              state, state_nxt;
   logic [IW-1:0]       idx;
   logic [BUF_AWID-1:0] base_q;
   logic [3:0]          num_q;
   logic                fail_q;
   logic                dec_pend;
   logic [ECC_AWID-1:0] addr_q;

   logic                start_enc, start_dec, start;
   logic                enc_last, dec_last, cap_skip;
   logic [BUF_AWID-1:0] par_addr, word_addr;
   logic [DAT_WID-1:0]  bit_mask;

   assign start_enc = nfc_ecc_opt &&  nfc_dat_dir && ecc_enc_rdy;
   assign start_dec = nfc_ecc_opt && !nfc_dat_dir && ecc_dec_rdy;
   // A decode job spends its first cycle in IDLE with dec_pend set, deciding on the early exits.
   assign start     = (state == IDLE) && !dec_pend && (start_enc || start_dec);

   assign enc_last  = (idx == IW'(PAR_WORDS - 1));
   assign dec_last  = ((idx + IW'(1)) == IW'(num_q));
   assign cap_skip  = (32'(mem_dec_addr) >= DATA_BITS);

   assign par_addr  = base_q + BUF_AWID'(PAR_OFS) + BUF_AWID'(idx);
   assign word_addr = base_q + BUF_AWID'(addr_q >> 4);
   assign bit_mask  = DAT_WID'(1) << addr_q[3:0];

   assign cor_busy  = (state != IDLE) || dec_pend;
   assign cor_done  = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         base_q   <= '0;
         num_q    <= '0;
         fail_q   <= 1'b0;
         dec_pend <= 1'b0;
         addr_q   <= '0;
         cor_cnt  <= '0;
         cor_fail <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start) begin
            base_q   <= sec_base;
            num_q    <= ecc_err_num;
            fail_q   <= ecc_fail;
            cor_cnt  <= '0;
            cor_fail <= 1'b0;
            idx      <= '0;
            dec_pend <= start_dec;
         end else if (dec_pend) begin
            dec_pend <= 1'b0;
            if (fail_q) cor_fail <= 1'b1;
         end
         case (state)
            E_WR: idx <= idx + IW'(1);
            D_CAP: begin
               addr_q <= mem_dec_addr;
               if (cap_skip) idx <= idx + IW'(1);
            end
            D_MOD: begin
               idx     <= idx + IW'(1);
               cor_cnt <= cor_cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      mem_if_rd = 1'b0;
      buf_rd    = 1'b0;
      buf_wr    = 1'b0;
      buf_addr  = '0;
      buf_wdat  = '0;
      case (state)
         IDLE: begin
            if (dec_pend)
               state_nxt = (fail_q || (num_q == 4'd0)) ? DONE : D_RD;
            else if (start && start_enc)
               state_nxt = E_RD;
         end
         E_RD: begin
            mem_if_rd = 1'b1;
            state_nxt = E_WR;
         end
         E_WR: begin
            buf_wr    = 1'b1;
            buf_addr  = par_addr;
            buf_wdat  = mem_enc_dat;
            state_nxt = enc_last ? DONE : E_RD;
         end
         D_RD: begin
            mem_if_rd = 1'b1;
            state_nxt = D_CAP;
         end
         D_CAP: begin
            // Parity-region addresses are not in the page buffer data area; skip them untouched.
            if (cap_skip)
               state_nxt = dec_last ? DONE : D_RD;
            else
               state_nxt = D_BRD;
         end
         D_BRD: begin
            buf_rd    = 1'b1;
            buf_addr  = word_addr;
            state_nxt = D_MOD;
         end
         D_MOD: begin
            buf_wr    = 1'b1;
            buf_addr  = word_addr;
            buf_wdat  = buf_rdat ^ bit_mask;
            state_nxt = dec_last ? DONE : D_RD;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_nfc_mem_cor.sv
// Bench for nfc_mem_cor: page-buffer and FIFO models, directed vector table plus reset/ignore sequences.
module tb_nfc_mem_cor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        nfc_dat_dir = 1'b0, nfc_ecc_opt = 1'b0, ecc_enc_rdy = 1'b0, ecc_dec_rdy = 1'b0;
   logic [3:0]  ecc_err_num = 4'd0;
   logic        ecc_fail = 1'b0;
   logic [8:0]  sec_base = 9'd0;
   logic        mem_if_rd;
   logic [15:0] mem_enc_dat = 16'd0;
   logic [12:0] mem_dec_addr = 13'd0;
   logic [8:0]  buf_addr;
   logic        buf_rd, buf_wr;
   logic [15:0] buf_wdat;
   logic [15:0] buf_rdat = 16'd0;
   logic        cor_busy, cor_done, cor_fail;
   logic [3:0]  cor_cnt;

   always #5 clk = ~clk;

   nfc_mem_cor dut (
      .clk(clk), .rst_n(rst_n), .nfc_dat_dir(nfc_dat_dir), .nfc_ecc_opt(nfc_ecc_opt),
      .ecc_enc_rdy(ecc_enc_rdy), .ecc_dec_rdy(ecc_dec_rdy), .ecc_err_num(ecc_err_num),
      .ecc_fail(ecc_fail), .sec_base(sec_base), .mem_if_rd(mem_if_rd), .mem_enc_dat(mem_enc_dat),
      .mem_dec_addr(mem_dec_addr), .buf_addr(buf_addr), .buf_rd(buf_rd), .buf_wr(buf_wr),
      .buf_wdat(buf_wdat), .buf_rdat(buf_rdat), .cor_busy(cor_busy), .cor_done(cor_done),
      .cor_fail(cor_fail), .cor_cnt(cor_cnt)
   );

   // Page buffer and FIFO models; the bench preloads them through poke/clear strobes.
   int          cyc = 0;
   int          rp = 0;
   logic [15:0] pb [0:511];
   logic [15:0] fifo_mem [0:15];
   logic        poke_en = 1'b0, fifo_clr = 1'b0;
   logic [8:0]  poke_addr = 9'd0;
   logic [15:0] poke_dat = 16'd0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (poke_en) pb[poke_addr] <= poke_dat;
      if (buf_wr)  pb[buf_addr] <= buf_wdat;
      if (buf_rd)  buf_rdat <= pb[buf_addr];
      if (fifo_clr) rp <= 0;
      else if (mem_if_rd) begin
         mem_enc_dat  <= fifo_mem[rp[3:0]];
         mem_dec_addr <= fifo_mem[rp[3:0]][12:0];
         rp <= rp + 1;
      end
   end

   int   n_rd = 0, n_wr = 0, n_busy = 0, n_viol = 0;
   logic prev_rd = 1'b0;
   always @(negedge clk) begin
      if (mem_if_rd) n_rd <= n_rd + 1;
      if (buf_wr)    n_wr <= n_wr + 1;
      if (cor_busy)  n_busy <= n_busy + 1;
      if ((mem_if_rd && prev_rd) || (buf_rd && buf_wr)) n_viol <= n_viol + 1;
      prev_rd <= mem_if_rd;
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic poke(input logic [8:0] a, input logic [15:0] d);
      @(negedge clk);
      poke_en = 1'b1; poke_addr = a; poke_dat = d;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic clear_fifo();
      @(negedge clk);
      fifo_clr = 1'b1;
      @(negedge clk);
      fifo_clr = 1'b0;
   endtask

   typedef struct {
      logic        dir;
      logic [3:0]  num;
      logic        fail;
      logic [8:0]  base;
      logic [12:0] a0, a1, a2;
      int          npre;
      logic [8:0]  pa0; logic [15:0] pd0;
      logic [8:0]  pa1; logic [15:0] pd1;
      int          restart;
      int          lat;
      logic [3:0]  cnt;
      logic        cfail;
      int          nfrd, nwr, nchk;
      logic [8:0]  ca0; logic [15:0] cd0;
      logic [8:0]  ca1; logic [15:0] cd1;
   } vec_t;

   task automatic run_vec(input int n, input vec_t v);
      int   b_rd, b_wr, t0, lat;
      logic got;
      logic [3:0] cnt;
      logic cf;
      logic [8:0] wa;
      if (v.npre > 0) poke(v.pa0, v.pd0);
      if (v.npre > 1) poke(v.pa1, v.pd1);
      if (v.dir) begin
         for (int k = 0; k < 7; k++) fifo_mem[k] = 16'h1111 * 16'(k + 1);
      end else begin
         fifo_mem[0] = {3'b000, v.a0};
         fifo_mem[1] = {3'b000, v.a1};
         fifo_mem[2] = {3'b000, v.a2};
      end
      clear_fifo();
      b_rd = n_rd; b_wr = n_wr;
      nfc_ecc_opt = 1'b1; nfc_dat_dir = v.dir; ecc_err_num = v.num; ecc_fail = v.fail;
      sec_base = v.base; ecc_enc_rdy = v.dir; ecc_dec_rdy = !v.dir;
      t0 = cyc;
      @(negedge clk);
      ecc_enc_rdy = 1'b0; ecc_dec_rdy = 1'b0;
      chk($sformatf("v%0d_busy_start", n), cor_busy, 1'b1);
      got = 1'b0; lat = 0; cnt = 4'd0; cf = 1'b0;
      while (!got && (cyc - t0) < 60) begin
         if (cor_done) begin
            got = 1'b1; lat = cyc - t0; cnt = cor_cnt; cf = cor_fail;
         end else begin
            if (v.restart != 0 && (cyc - t0) == v.restart) begin
               ecc_enc_rdy = v.dir; ecc_dec_rdy = !v.dir;
               ecc_err_num = 4'd15; ecc_fail = 1'b1; sec_base = 9'h111;
            end
            @(negedge clk);
            ecc_enc_rdy = 1'b0; ecc_dec_rdy = 1'b0;
         end
      end
      chk($sformatf("v%0d_done_seen", n), got, 1'b1);
      chk($sformatf("v%0d_latency", n), lat, v.lat);
      chk($sformatf("v%0d_cor_cnt", n), cnt, v.cnt);
      chk($sformatf("v%0d_cor_fail", n), cf, v.cfail);
      @(negedge clk);
      chk($sformatf("v%0d_idle_after", n), {cor_busy, cor_done}, 2'b00);
      chk($sformatf("v%0d_fifo_reads", n), n_rd - b_rd, v.nfrd);
      chk($sformatf("v%0d_buf_writes", n), n_wr - b_wr, v.nwr);
      if (v.dir) begin
         for (int k = 0; k < 7; k++) begin
            wa = v.base + 9'h100 + 9'(k);
            chk($sformatf("v%0d_par%0d", n, k), pb[wa], 16'h1111 * 16'(k + 1));
         end
      end else begin
         if (v.nchk > 0) chk($sformatf("v%0d_word0", n), pb[v.ca0], v.cd0);
         if (v.nchk > 1) chk($sformatf("v%0d_word1", n), pb[v.ca1], v.cd1);
      end
   endtask

   vec_t vt [9];

   initial begin
      int b_busy, b_rd;
      //          dir  num   fail base    a0       a1       a2     np pa0   pd0       pa1   pd1      rs lat cnt  cf nrd nwr nc ca0   cd0       ca1   cd1
      vt[0] = '{1'b1,4'd0,1'b0,9'h000,13'h0000,13'h0000,13'h0000, 0,9'h000,16'h0000,9'h000,16'h0000, 0,15,4'd0,1'b0,7,7,0,9'h000,16'h0000,9'h000,16'h0000};
      vt[1] = '{1'b0,4'd1,1'b0,9'h000,13'h0105,13'h0000,13'h0000, 1,9'h010,16'hFFFF,9'h000,16'h0000, 0, 6,4'd1,1'b0,1,1,1,9'h010,16'hFFDF,9'h000,16'h0000};
      vt[2] = '{1'b0,4'd3,1'b0,9'h000,13'h0000,13'h1005,13'h0FFF, 2,9'h000,16'h0000,9'h0FF,16'h0000, 0,12,4'd2,1'b0,3,2,2,9'h000,16'h0001,9'h0FF,16'h8000};
      vt[3] = '{1'b0,4'd3,1'b1,9'h000,13'h0000,13'h0010,13'h0020, 1,9'h000,16'h5555,9'h000,16'h0000, 0, 2,4'd0,1'b1,0,0,1,9'h000,16'h5555,9'h000,16'h0000};
      vt[4] = '{1'b0,4'd0,1'b0,9'h000,13'h0000,13'h0000,13'h0000, 0,9'h000,16'h0000,9'h000,16'h0000, 0, 2,4'd0,1'b0,0,0,0,9'h000,16'h0000,9'h000,16'h0000};
      vt[5] = '{1'b1,4'd0,1'b0,9'h180,13'h0000,13'h0000,13'h0000, 0,9'h000,16'h0000,9'h000,16'h0000, 0,15,4'd0,1'b0,7,7,0,9'h000,16'h0000,9'h000,16'h0000};
      vt[6] = '{1'b0,4'd2,1'b0,9'h005,13'h0023,13'h0023,13'h0000, 1,9'h007,16'h1234,9'h000,16'h0000, 3,10,4'd2,1'b0,2,2,1,9'h007,16'h1234,9'h000,16'h0000};
      vt[7] = '{1'b0,4'd1,1'b0,9'h1FF,13'h0010,13'h0000,13'h0000, 1,9'h000,16'hAAAA,9'h000,16'h0000, 0, 6,4'd1,1'b0,1,1,1,9'h000,16'hAAAB,9'h000,16'h0000};
      vt[8] = '{1'b0,4'd2,1'b0,9'h000,13'h1FFF,13'h1000,13'h0000, 0,9'h000,16'h0000,9'h000,16'h0000, 0, 6,4'd0,1'b0,2,0,0,9'h000,16'h0000,9'h000,16'h0000};

      repeat (2) @(negedge clk);
      chk("reset_outputs", {mem_if_rd, buf_rd, buf_wr, cor_busy, cor_done, cor_fail,
                            buf_addr, buf_wdat, cor_cnt}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int n = 0; n < 9; n++) run_vec(n, vt[n]);

      // Starts with ECC disabled or with the pulse not matching the direction must be dropped.
      b_busy = n_busy; b_rd = n_rd;
      @(negedge clk);
      nfc_ecc_opt = 1'b0; nfc_dat_dir = 1'b1; ecc_enc_rdy = 1'b1;
      @(negedge clk);
      ecc_enc_rdy = 1'b0; nfc_ecc_opt = 1'b1; ecc_dec_rdy = 1'b1;
      @(negedge clk);
      ecc_dec_rdy = 1'b0; nfc_dat_dir = 1'b0; ecc_enc_rdy = 1'b1;
      @(negedge clk);
      ecc_enc_rdy = 1'b0;
      repeat (20) @(negedge clk);
      chk("ignored_busy_cycles", n_busy - b_busy, 0);
      chk("ignored_fifo_reads", n_rd - b_rd, 0);

      // Reset asserted while the read-modify-write is on its write cycle.
      poke(9'h010, 16'hFFFF);
      fifo_mem[0] = 16'h0105;
      clear_fifo();
      nfc_ecc_opt = 1'b1; nfc_dat_dir = 1'b0; ecc_err_num = 4'd1; ecc_fail = 1'b0;
      sec_base = 9'h000; ecc_dec_rdy = 1'b1;
      @(negedge clk);
      ecc_dec_rdy = 1'b0;
      for (int k = 0; k < 20 && !buf_rd; k++) @(negedge clk);
      chk("rmw_read_seen", buf_rd, 1'b1);
      @(negedge clk);
      chk("rmw_write_cycle", buf_wr, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("reset_mid_outputs", {mem_if_rd, buf_rd, buf_wr, cor_busy, cor_done, cor_fail,
                                buf_addr, buf_wdat, cor_cnt}, 64'd0);
      @(negedge clk);
      chk("reset_mid_no_write", pb[9'h010], 16'hFFFF);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(9, vt[1]);

      chk("protocol_violations", n_viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/nfc_mem_cor.md
# nfc_mem_cor

Memory-interface-side consumer of the ECC result FIFO. It runs in the `clk` domain.
- Program direction: it drains the BCH parity words out of the FIFO and writes them into the page buffer's spare area.
- Read direction: it drains the error bit addresses out of the FIFO and corrects each one with a read-modify-write bit flip in the page buffer.
- It sits between the ECC correction FIFO and the page-buffer SRAM port and reports completion to the NFC controller FSM.

## Interface
Parameters:
- DAT_WID, 16: FIFO and page-buffer word width.
- ECC_AWID, 13: error bit-address width. Covers data plus parity bits of one sector.
- BUF_AWID, 9: page-buffer word-address width.
- DATA_BITS, 4096: data bits per sector. Error addresses at or above this value lie in parity and are skipped.
- PAR_WORDS, 7: parity words per sector.
- PAR_OFS, 256: word offset of parity from the sector base.

Ports:
- clk  in  1  system clock. One clock only.
- rst_n  in  1  asynchronous active-low reset.
- nfc_dat_dir  in  1  1 = program (encode), 0 = read (decode).
- nfc_ecc_opt  in  1  ECC enable. When 0, start pulses are ignored.
- ecc_enc_rdy  in  1  1-cycle pulse: parity available in the FIFO.
- ecc_dec_rdy  in  1  1-cycle pulse: decode finished, error addresses available.
- ecc_err_num  in  4  number of error addresses in the FIFO. Sampled at start.
- ecc_fail  in  1  uncorrectable flag. Sampled at start.
- sec_base  in  BUF_AWID  sector base word address. Sampled at start.
- mem_if_rd  out  1  FIFO read strobe.
- mem_enc_dat  in  DAT_WID  FIFO parity word. Valid the cycle after mem_if_rd.
- mem_dec_addr  in  ECC_AWID  FIFO error bit address. Valid the cycle after mem_if_rd.
- buf_addr  out  BUF_AWID  page-buffer address.
- buf_rd  out  1  page-buffer read. buf_rdat is valid the following cycle.
- buf_wr  out  1  page-buffer write.
- buf_wdat  out  DAT_WID  page-buffer write data.
- buf_rdat  in  DAT_WID  page-buffer read data.
- cor_busy  out  1  engine active.
- cor_done  out  1  1-cycle completion pulse.
- cor_fail  out  1  sticky until next start: sector uncorrectable.
- cor_cnt  out  4  bits actually flipped in the last sector. Held until next start.

## Operation
- States: IDLE, E_RD, E_WR, D_RD, D_CAP, D_BRD, D_MOD, DONE.
- Start condition: IDLE, nfc_ecc_opt=1, and either
  - ecc_enc_rdy with nfc_dat_dir=1 → encode job, or
  - ecc_dec_rdy with nfc_dat_dir=0 → decode job.
- Start actions: latch sec_base, ecc_err_num and ecc_fail; clear cor_cnt and cor_fail; clear index counter i.
- Start pulses arriving in any state other than IDLE are ignored.
- Encode loop, runs for i = 0..PAR_WORDS-1:
  - E_RD: mem_if_rd=1.
  - E_WR: buf_wr=1, buf_addr = sec_base+PAR_OFS+i, buf_wdat = mem_enc_dat.
  - After the last word, go to DONE.
- Decode, early exits:
  - ecc_fail=1 → DONE with cor_fail=1. No FIFO reads, no buffer writes.
  - err_num=0 → DONE directly.
- Decode loop, per error:
  - D_RD: mem_if_rd=1.
  - D_CAP: latch mem_dec_addr. If the address is ≥ DATA_BITS, skip to the next error (or DONE after the last) with no buffer access.
  - D_BRD: buf_rd=1, buf_addr = sec_base + addr[ECC_AWID-1:4].
  - D_MOD: buf_wr=1 at the same address, buf_wdat = buf_rdat ^ (1 << addr[3:0]); cor_cnt increments.
- DONE: cor_done=1 for one cycle, then return to IDLE.
- Address arithmetic: modulo 2^BUF_AWID. Wrap-around is silent.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE.
- Async reset mid-job aborts immediately. Any partially drained FIFO contents are abandoned.
- cor_busy=1 from the cycle after the start pulse until DONE inclusive.
- Encode latency: start + 2·PAR_WORDS + 1 cycles to cor_done. With default parameters (PAR_WORDS=7) cor_done is 15 cycles after the start pulse.
- Decode latency:
  - In-range error: 4 cycles each.
  - Skipped (parity) error: 2 cycles each.
  - cor_done then follows 1 cycle after the last error.
  - ecc_fail or err_num=0: cor_done 2 cycles after start.
- mem_if_rd is never asserted on two consecutive cycles.
- buf_rd and buf_wr are never asserted in the same cycle.
- Duplicate addresses are processed in order, so the same bit is flipped twice and cor_cnt counts both.

## Test plan
- Encode: FIFO preloaded with 0x1111..0x7777, sec_base=0x000, start → buffer words 0x100..0x106 = 0x1111..0x7777 and cor_done 15 cycles after start.
- Decode, single error: buf[0x010]=0xFFFF, err addr 0x0105, sec_base=0x000 → buf[0x010]=0xFFDF, cor_cnt=1, cor_done 6 cycles after start.
- Decode, mixed errors: addrs {0x0000, 0x1005 (parity), 0x0FFF} → bit0 of word 0x00 and bit15 of word 0xFF flipped; no access for 0x1005; cor_cnt=2.
- Decode with ecc_fail=1, err_num=3 → no mem_if_rd, no buf_wr; cor_fail=1 and cor_done 2 cycles after start.
- nfc_ecc_opt=0, or a second start during busy → ignored, and the first job completes unchanged.
- rst_n dropped during D_MOD → all outputs 0 immediately, no buf_wr. A new start after reset runs normally.
